// File: rtl/stim_arb_pkg.sv
// Shared types and width helpers for the stimulus bus arbiter.
package stim_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    REVOKE = 2'd2
  } arb_state_e;

  function automatic int gid_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/stim_bus_arbiter_if.sv
// Requester-side and DUT-side signals of the stimulus bus arbiter.
// master = arbiter view, slave = requesters plus downstream DUT.
interface stim_bus_arbiter_if
  import stim_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int GW = gid_width(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          bus_valid;
  logic                          bus_ready;
  logic [ADDR_WIDTH-1:0]         bus_addr;
  logic [DATA_WIDTH-1:0]         bus_data;
  logic                          bus_last;
  logic [GW-1:0]                 grant_id;
  logic                          err_timeout;

  modport master (
    input  req_valid, req_last, req_addr, req_data, bus_ready,
    output req_ready, bus_valid, bus_addr, bus_data, bus_last, grant_id, err_timeout
  );

  modport slave (
    output req_valid, req_last, req_addr, req_data, bus_ready,
    input  req_ready, bus_valid, bus_addr, bus_data, bus_last, grant_id, err_timeout
  );
endinterface

// File: rtl/stim_rr_picker.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr, wrapping.
module stim_rr_picker
  import stim_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [gid_width(NUM_REQ)-1:0]      rr_ptr_i,
  output logic                               any_valid_o,
  output logic [gid_width(NUM_REQ)-1:0]      winner_o
);
  localparam int GW = gid_width(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic [GW-1:0]        off_s;
  logic [GW:0]          sum_s;

  assign any_valid_o = |req_valid_i;

  // Rotate so rr_ptr sits at bit 0, then take the lowest set offset.
  always_comb begin
    dbl_s = {req_valid_i, req_valid_i} >> rr_ptr_i;
    rot_s = dbl_s[NUM_REQ-1:0];
    off_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        off_s = GW'(k);
      end else begin
        off_s = off_s;
      end
    end
    sum_s = {1'b0, rr_ptr_i} + {1'b0, off_s};
    if (sum_s >= (GW+1)'(NUM_REQ)) begin
      winner_o = GW'(sum_s - (GW+1)'(NUM_REQ));
    end else begin
      winner_o = GW'(sum_s);
    end
  end
endmodule

// File: rtl/stim_bus_arbiter.sv
// Round-robin burst arbiter sharing one write bus among NUM_REQ stimulus generators.
// Optional stall revocation is enabled with the ARB_TIMEOUT_EN macro.
module stim_bus_arbiter
  import stim_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  stim_bus_arbiter_if.master bus
);
  localparam int GW = gid_width(NUM_REQ);
  localparam int CW = cnt_width(MAX_BURST);

  arb_state_e    state_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] rr_ptr_q;
  logic [CW-1:0] beat_cnt_q;

  logic          any_valid_s;
  logic [GW-1:0] winner_s;
  logic          in_burst_s;
  logic          owner_valid_s;
  logic          bus_valid_s;
  logic          beat_s;
  logic          last_s;
  logic [GW-1:0] next_ptr_s;

  stim_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid_i (bus.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .any_valid_o (any_valid_s),
    .winner_o    (winner_s)
  );

  assign in_burst_s    = (state_q == BURST);
  assign owner_valid_s = bus.req_valid[grant_q];
  assign bus_valid_s   = in_burst_s & owner_valid_s;
  assign beat_s        = bus_valid_s & bus.bus_ready;
  assign last_s        = bus_valid_s &
                         (bus.req_last[grant_q] | (beat_cnt_q == CW'(MAX_BURST - 1)));
  assign next_ptr_s    = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);

  assign bus.bus_valid = bus_valid_s;
  assign bus.bus_last  = last_s;
  assign bus.grant_id  = grant_q;
  assign bus.req_ready = in_burst_s ? (NUM_REQ'(bus.bus_ready) << grant_q) : '0;
  assign bus.bus_addr  = in_burst_s ?
                         ADDR_WIDTH'(bus.req_addr >> (int'(grant_q) * ADDR_WIDTH)) : '0;
  assign bus.bus_data  = in_burst_s ?
                         DATA_WIDTH'(bus.req_data >> (int'(grant_q) * DATA_WIDTH)) : '0;

`ifdef ARB_TIMEOUT_EN
  localparam int SW = cnt_width(TIMEOUT);
  logic [SW-1:0] stall_q;
  logic          err_q;
  assign bus.err_timeout = err_q;
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT);
  assign bus.err_timeout  = 1'b0;
`endif

  // Grant FSM: pick on IDLE, hold until a last beat (or a stall revoke), then rotate.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
`ifdef ARB_TIMEOUT_EN
      stall_q    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (any_valid_s) begin
            state_q <= BURST;
            grant_q <= winner_s;
          end
        end
        BURST: begin
          if (beat_s && last_s) begin
            state_q    <= IDLE;
            rr_ptr_q   <= next_ptr_s;
            beat_cnt_q <= '0;
          end else if (beat_s) begin
            beat_cnt_q <= beat_cnt_q + CW'(1);
          end
`ifdef ARB_TIMEOUT_EN
          if (owner_valid_s) begin
            stall_q <= '0;
          end else if (stall_q == SW'(TIMEOUT - 1)) begin
            state_q <= REVOKE;
            err_q   <= 1'b1;
            stall_q <= '0;
          end else begin
            stall_q <= stall_q + SW'(1);
          end
`endif
        end
        REVOKE: begin
          state_q    <= IDLE;
          rr_ptr_q   <= next_ptr_s;
          beat_cnt_q <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stim_bus_arbiter.sv
// Scoreboard bench for stim_bus_arbiter: directed bursts, expected beats queued up front.
module tb_stim_bus_arbiter;
  import stim_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stim_bus_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

  stim_bus_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB), .TIMEOUT(TO)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bif)
  );

  typedef struct packed {
    logic [1:0]    gid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] ra [NR][64];
  logic [DW-1:0] rdat [NR][64];
  logic          rl [NR][64];
  int            wr [NR];
  int            rd [NR];
  int            n_tests = 0;
  int            n_fail  = 0;

  function automatic logic [AW-1:0] mk_addr(input int r, input int k);
    return {8'hAD, 8'(r), 16'(k)};
  endfunction

  function automatic logic [DW-1:0] mk_data(input int r, input int k);
    return {8'hDA, 8'(r), 16'(k)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic push_burst(input int r, input int k0, input int n, input logic last_end);
    for (int j = 0; j < n; j++) begin
      ra[r][wr[r]]   = mk_addr(r, k0 + j);
      rdat[r][wr[r]] = mk_data(r, k0 + j);
      rl[r][wr[r]]   = last_end && (j == n - 1);
      wr[r]++;
    end
  endtask

  task automatic exp_beat(input int r, input int k, input logic last);
    beat_t b;
    b.gid  = 2'(r);
    b.addr = mk_addr(r, k);
    b.data = mk_data(r, k);
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic exp_burst(input int r, input int k0, input int n);
    for (int j = 0; j < n; j++) exp_beat(r, k0 + j, j == n - 1);
  endtask

  task automatic drain(input string nm);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_drained"}, exp_q.size(), 0);
    @(negedge clk);
    chk({nm, "_idle"}, bif.bus_valid, 1'b0);
  endtask

  // Requester models: present the head beat, advance when the monitor saw it accepted.
  initial begin
    logic [NR-1:0]    v;
    logic [NR-1:0]    l;
    logic [NR*AW-1:0] a;
    logic [NR*DW-1:0] d;
    bif.req_valid = '0;
    bif.req_last  = '0;
    bif.req_addr  = '0;
    bif.req_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      v = '0; l = '0; a = '0; d = '0;
      for (int i = 0; i < NR; i++) begin
        if (rd[i] < wr[i]) begin
          v[i]           = 1'b1;
          l[i]           = rl[i][rd[i]];
          a[i*AW +: AW]  = ra[i][rd[i]];
          d[i*DW +: DW]  = rdat[i][rd[i]];
        end
      end
      bif.req_valid = v;
      bif.req_last  = l;
      bif.req_addr  = a;
      bif.req_data  = d;
    end
  end

  // Monitor: every accepted bus beat is popped against the scoreboard.
  initial begin
    beat_t got;
    beat_t want;
    forever begin
      @(negedge clk);
      if (!rst && bif.bus_valid && bif.bus_ready) begin
        got.gid  = bif.grant_id;
        got.addr = bif.bus_addr;
        got.data = bif.bus_data;
        got.last = bif.bus_last;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", got);
        end else begin
          want = exp_q.pop_front();
          chk("beat", got, want);
        end
        for (int i = 0; i < NR; i++) begin
          if (bif.req_valid[i] && bif.req_ready[i]) rd[i]++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bif.bus_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bus_valid", bif.bus_valid, 1'b0);
    chk("rst_req_ready", bif.req_ready, 4'b0000);
    chk("rst_grant_id", bif.grant_id, 2'd0);
    chk("rst_err", bif.err_timeout, 1'b0);
    chk("rst_addr", bif.bus_addr, 32'h0);
    chk("rst_last", bif.bus_last, 1'b0);
    rst = 1'b0;

    // All four requesting, two 2-beat bursts each: strict rotation 0,1,2,3,0,1,2,3.
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      push_burst(r, 1, 2, 1'b1);
      push_burst(r, 3, 2, 1'b1);
    end
    for (int rnd = 0; rnd < 2; rnd++)
      for (int r = 0; r < NR; r++) exp_burst(r, rnd * 2 + 1, 2);
    drain("rr");

    // Single requester 2, three beats: latency, grant id, last, idle gap.
    @(negedge clk);
    exp_burst(2, 5, 3);
    push_burst(2, 5, 3, 1'b1);
    @(negedge clk);
    chk("t1_req_cycle_valid", bif.bus_valid, 1'b0);
    @(negedge clk);
    chk("t1_valid", bif.bus_valid, 1'b1);
    chk("t1_grant", bif.grant_id, 2'd2);
    @(negedge clk);
    chk("t1_beat2_last", bif.bus_last, 1'b0);
    @(negedge clk);
    chk("t1_beat3_last", bif.bus_last, 1'b1);
    @(negedge clk);
    chk("t1_gap", bif.bus_valid, 1'b0);
    drain("t1");

    // Requester 1, ten beats with last only on beat 10: forced splits at beats 4 and 8.
    @(negedge clk);
    for (int j = 0; j < 10; j++) exp_beat(1, 5 + j, (j == 3) || (j == 7) || (j == 9));
    push_burst(1, 5, 10, 1'b1);
    drain("split");

    // bus_ready low for 5 cycles while beat 2 of requester 3 is pending.
    @(negedge clk);
    exp_burst(3, 5, 4);
    push_burst(3, 5, 4, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    bif.bus_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", bif.bus_valid, 1'b1);
      chk("stall_addr", bif.bus_addr, mk_addr(3, 6));
      chk("stall_data", bif.bus_data, mk_data(3, 6));
    end
    @(posedge clk);
    #2;
    bif.bus_ready = 1'b1;
    drain("stall");

`ifdef ARB_TIMEOUT_EN
    // Owner 0 goes silent after one beat; requester 1 waits behind it.
    @(negedge clk);
    exp_beat(0, 5, 1'b0);
    exp_beat(1, 15, 1'b1);
    push_burst(0, 5, 1, 1'b0);
    push_burst(1, 15, 1, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      chk($sformatf("timeout_err_c%0d", k), bif.err_timeout, k == 11);
      if (k == 13) chk("timeout_next_grant", bif.grant_id, 2'd1);
    end
    drain("timeout");
`endif

    // Reset in the middle of a requester 3 burst.
    @(negedge clk);
    exp_burst(3, 9, 3);
    push_burst(3, 9, 3, 1'b1);
    c = 0;
    while (!bif.bus_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("mid_granted", bif.bus_valid, 1'b1);
    chk("mid_grant_id", bif.grant_id, 2'd3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bif.bus_valid, 1'b0);
    chk("mid_rst_ready", bif.req_ready, 4'b0000);
    chk("mid_rst_grant", bif.grant_id, 2'd0);
    chk("mid_rst_addr", bif.bus_addr, 32'h0);
    chk("mid_rst_data", bif.bus_data, 32'h0);
    chk("mid_rst_last", bif.bus_last, 1'b0);
    exp_q.delete();
    for (int i = 0; i < NR; i++) wr[i] = rd[i];
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_burst(0, 6, 1);
    exp_burst(2, 8, 1);
    push_burst(2, 8, 1, 1'b1);
    push_burst(0, 6, 1, 1'b1);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stim_bus_arbiter.md
# stim_bus_arbiter

Round-robin arbiter that shares one address/data write bus between `NUM_REQ` stimulus generators in the simulation and FPGA test environment. Each requester streams bursts of addr/data beats with valid/ready handshakes. The arbiter grants one requester per burst and holds the grant until the last beat. It enforces a maximum burst length and a fair rotation, so that counter-style generators can drive a single DUT port.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `DATA_WIDTH`, 32, data beat width
- `ADDR_WIDTH`, 32, address width
- `MAX_BURST`, 16, maximum beats per grant (≥1)
- `TIMEOUT`, 64, stall cycles before a grant is revoked (only with the macro)
- `sys_clk  in  1  clock; all logic on rising edge`
- `sys_rst  in  1  reset, asynchronous, active-high`
- `req_valid  in  NUM_REQ  per-requester beat valid`
- `req_last  in  NUM_REQ  per-requester last beat of burst`
- `req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]`
- `req_data  in  NUM_REQ*DATA_WIDTH  flattened, same packing`
- `req_ready  out  NUM_REQ  per-requester beat accept`
- `bus_valid  out  1  beat valid toward DUT`
- `bus_ready  in  1  DUT accepts beat`
- `bus_addr  out  ADDR_WIDTH  granted address`
- `bus_data  out  DATA_WIDTH  granted data`
- `bus_last  out  1  last beat (requester last, or forced at MAX_BURST)`
- `grant_id  out  $clog2(NUM_REQ)  index of the current owner`
- `err_timeout  out  1  one-cycle pulse when a grant is revoked`

## Operation
- States:
  - IDLE: no grant.
  - BURST: grant held by `grant_id`.
  - With `ARB_TIMEOUT_EN` only, REVOKE: a single cycle.
- IDLE → BURST:
  - Any `req_valid` high moves the arbiter to BURST.
  - The winner is the first requester with valid high at or after `rr_ptr`, scanning upward with wrap.
  - `grant_id` is registered on that edge.
- In BURST:
  - `bus_valid = req_valid[grant_id]` and `req_ready[grant_id] = bus_ready`.
  - All other `req_ready` are 0.
  - `bus_addr` and `bus_data` are muxed from the owner.
- Beat:
  - A beat is `bus_valid & bus_ready`.
  - `beat_cnt` (width `$clog2(MAX_BURST+1)`) increments per beat.
- `bus_last = req_last[grant_id] | (beat_cnt == MAX_BURST-1)`, gated by `bus_valid`.
- A beat carrying `bus_last` ends the burst:
  - BURST → IDLE.
  - `rr_ptr` becomes `grant_id+1` modulo `NUM_REQ`.
  - `beat_cnt` clears to 0.
- A forced split at `MAX_BURST`:
  - The requester's remaining beats wait for a later grant.
  - The requester is not notified other than by `bus_last`.
- Lower `req_valid` by the owner mid-burst: the grant is held and `bus_valid` is 0.
- Outside BURST: `bus_valid`, `bus_last`, `bus_addr`, `bus_data`, and all `req_ready` are 0.
- `req_*` changes from non-owners are ignored while a grant is held.

## Timing
- Reset values:
  - `req_ready = 0`, `bus_valid = 0`, `bus_addr = 0`, `bus_data = 0`, `bus_last = 0`.
  - `grant_id = 0`, `err_timeout = 0`.
  - `rr_ptr = 0`, `beat_cnt = 0`, state IDLE.
- Reset mid-burst drops the grant immediately (asynchronous). The partially sent burst is not resumed.
- Latency:
  - A request in cycle N gives `bus_valid` in cycle N+1.
  - Minimum gap between bursts is 1 IDLE cycle after the last beat.
- Single-beat burst: `req_last` on the first beat; BURST lasts 1 cycle if `bus_ready` = 1.
- `MAX_BURST = 1`: every beat carries `bus_last`.
- Simultaneous requests: rotation is strict; no requester is granted twice while another valid requester waits.
- `rr_ptr` wrap: after owner `NUM_REQ-1` finishes, the pointer goes to 0.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - `stall_cnt` counts consecutive BURST cycles with `req_valid[grant_id] = 0`, and resets on any owner valid.
  - When it reaches `TIMEOUT`, the arbiter enters REVOKE for 1 cycle: `err_timeout = 1`, `bus_valid = 0`.
  - From REVOKE it goes to IDLE, with `rr_ptr = grant_id+1` and `beat_cnt` cleared.
- Not defined: no `stall_cnt` and no REVOKE state. A stalled owner holds the grant indefinitely. `err_timeout` is tied 0.

## Structure
- Package `stim_arb_pkg`:
  - state enum (IDLE, BURST, REVOKE);
  - width helper constants for `grant_id` and `beat_cnt`.
- Sub-module `stim_rr_picker`:
  - combinational; takes `req_valid` and `rr_ptr`;
  - outputs `any_valid` and `winner` index.

## Test plan
- Single requester 2, burst of 3 beats, `bus_ready` = 1:
  - `bus_valid` is high from one cycle after the request, `grant_id` = 2.
  - `bus_last` is on beat 3, then 1 IDLE cycle follows.
- All 4 requesting continuously, 2-beat bursts: grant order 0,1,2,3,0; each gets exactly 2 beats per grant.
- `MAX_BURST` = 4, requester 1 sends 10 beats with `req_last` only on beat 10:
  - splits occur after beats 4 and 8, with `bus_last` forced on beats 4 and 8;
  - the remaining beats follow in later grants.
- `bus_ready` low for 5 cycles mid-burst: `bus_addr`/`bus_data` hold, no beat is lost, `beat_cnt` is unchanged.
- With `ARB_TIMEOUT_EN`, `TIMEOUT` = 8: the owner drops valid after beat 1, giving `err_timeout` = 1 exactly 9 cycles later, then the next requester is granted.
- `sys_rst` asserted mid-burst: all outputs are 0 in the same cycle; after release, requester 0 wins first.
